mips_multicycle_ctrl: RTL and testbench

//   Multicycle MIPS control FSM: decodes opcode/funct, sequences fetch/decode/execute/mem/writeback,
//   and drives datapath selects plus the 4-bit ALUcontrol code consumed by the ALU.

---
 rtl/mips_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM.
// Decodes opcode/funct, steps through fetch/decode/execute/memory/writeback,
// and drives the datapath selects and the 4-bit ALUcontrol code. Memory states
// wait on mem_ready and give up after MEM_TIMEOUT cycles, returning to FETCH
// with a one-cycle mem_err pulse.
//
// Optional feature macro: MIPS_CTRL_BNE_EN
//   defined   : opcode 0x05 (bne) is executed in BRANCH with pc_en = ~isZero
//   undefined : opcode 0x05 decodes as illegal
//
// state   | meaning
// --------+------------------------------------------------------------
// RST     | post-reset idle cycle, every output low
// FETCH   | read instruction at PC, PC+4 -> PC and IR latch on mem_ready
// DECODE  | branch target PC+(imm<<2) -> ALUOut, dispatch on opcode/funct
// MEMADR  | effective address regA+imm for lw/sw
// MEMRD   | data read at ALUOut, wait for mem_ready
// MEMWB   | MDR -> rt
// MEMWR   | data write at ALUOut, wait for mem_ready
// EXEC    | R-type ALU operation regA op regB
// ALUWB   | ALUOut -> rd
// BRANCH  | compare regA-regB, load PC from ALUOut when taken
// ADDIEX  | regA + imm
// ADDIWB  | ALUOut -> rt
// JUMP    | load PC with jump target
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMER_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       isZero,
    input  logic       mem_ready,
    output logic [3:0] ALUcontrol,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Last count value a memory state may wait through before it aborts.
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   cnt_q, cnt_d;
    logic                 timeout_hit;
    logic                 funct_ok;
    logic [3:0]           alu_fn;
    logic                 br_taken;

    // A timeout only counts when mem_ready is low; ready in that cycle completes normally.
    assign timeout_hit = (cnt_q == TMO_LAST) && !mem_ready;
    assign state_dbg   = state_q;

`ifdef MIPS_CTRL_BNE_EN
    assign br_taken = (opcode == OP_BNE) ? ~isZero : isZero;
`else
    assign br_taken = isZero;
`endif

    // R-type funct decode: ALU operation and legality.
    always_comb begin
        funct_ok = 1'b1;
        alu_fn   = ALU_AND;
        case (funct)
            FN_ADD:  alu_fn = ALU_ADD;
            FN_SUB:  alu_fn = ALU_SUB;
            FN_AND:  alu_fn = ALU_AND;
            FN_OR:   alu_fn = ALU_OR;
            FN_NOR:  alu_fn = ALU_NOR;
            FN_SLT:  alu_fn = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state and Moore output decode (pc_en additionally follows mem_ready/isZero).
    always_comb begin
        state_d    = state_q;
        ALUcontrol = 4'd0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        PCSource   = 2'd0;
        pc_en      = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'd1;
                ALUcontrol = ALU_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB    = 2'd3;
                ALUcontrol = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ALUcontrol = ALU_ADD;
                state_d    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = alu_fn;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_SUB;
                PCSource   = 2'd1;
                pc_en      = br_taken;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'd2;
                ALUcontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'd2;
                pc_en    = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // Wait counter: counts only while a memory state keeps waiting, cleared on any move
    // (including the FETCH->FETCH retry after a timeout).
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
            (state_d == state_q) && !timeout_hit) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: builds the expected per-cycle control trace
// of each instruction from its class and memory latencies, then drives and
// compares cycle by cycle; a dispatch table checks decode results directly.
module tb_mips_multicycle_ctrl;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h0;
    logic [5:0] funct = 6'h0;
    logic       isZero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] ALUcontrol;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, illegal, mem_err;
    logic [3:0] state_dbg;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TIMER_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .isZero(isZero), .mem_ready(mem_ready),
        .ALUcontrol(ALUcontrol), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal),
        .mem_err(mem_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pc_en;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       rw;
        logic       ill;
        logic       merr;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       iz;
        out_t       exp;
        int         id;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       exp_ill;
        logic [3:0] exp_next;
        logic [3:0] exp_alu;
    } disp_t;

    out_t act;
    assign act = {state_dbg, ALUcontrol, ALUSrcA, ALUSrcB, PCSource, pc_en, IorD,
                  MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, illegal, mem_err};

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cur_id = 0;
    logic [5:0] cur_op, cur_fn;
    logic [5:0] legal_fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s #%0d actual %h expected %h", nm, id, a, e);
        end
    endtask

    // Control outputs each step of an instruction is required to show.
    function automatic out_t step_out(input int st);
        out_t o = '0;
        o.st = 4'(st);
        case (st)
            1:  begin o.mrd = 1; o.srcb = 1; o.alu = 2; end
            2:  begin o.srcb = 3; o.alu = 2; end
            3:  begin o.srca = 1; o.srcb = 2; o.alu = 2; end
            4:  begin o.mrd = 1; o.iord = 1; end
            5:  begin o.rw = 1; o.m2r = 1; end
            6:  begin o.mwr = 1; o.iord = 1; end
            7:  begin o.srca = 1; end
            8:  begin o.rw = 1; o.regdst = 1; end
            9:  begin o.srca = 1; o.alu = 6; o.pcsrc = 1; end
            10: begin o.srca = 1; o.srcb = 2; o.alu = 2; end
            11: begin o.rw = 1; end
            12: begin o.pcsrc = 2; o.pc_en = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'd2;
            6'h22: return 4'd6;
            6'h24: return 4'd0;
            6'h25: return 4'd1;
            6'h27: return 4'd12;
            6'h2A: return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            for (int i = 0; i < 6; i++) if (fn == legal_fns[i]) return 1;
            return 0;
        end
        if (op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02) return 1;
`ifdef MIPS_CTRL_BNE_EN
        if (op == 6'h05) return 1;
`endif
        return 0;
    endfunction

    task automatic push(input out_t o, input logic rst, input logic rdy, input logic iz);
        cyc_t c;
        c.rst = rst; c.op = cur_op; c.fn = cur_fn; c.rdy = rdy; c.iz = iz;
        c.exp = o; c.id = cur_id;
        q.push_back(c);
    endtask

    // A memory wait of 'lat' idle cycles; lat >= TMO means ready never comes.
    task automatic wait_phase(input int st, input int lat, output bit ok);
        out_t o;
        if (lat >= TMO) begin
            for (int i = 0; i < TMO; i++) begin
                o = step_out(st);
                if (i == TMO - 1) o.merr = 1;
                push(o, 1'b1, 1'b0, 1'($urandom));
            end
            ok = 0;
        end else begin
            for (int i = 0; i < lat; i++) push(step_out(st), 1'b1, 1'b0, 1'($urandom));
            o = step_out(st);
            if (st == 1) begin o.irw = 1; o.pc_en = 1; end
            push(o, 1'b1, 1'b1, 1'($urandom));
            ok = 1;
        end
    endtask

    // izmode: 0/1 force isZero in BRANCH, 2 random.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int flat, input int mlat, input int izmode);
        bit   ok;
        out_t o;
        logic iz;
        cur_id++;
        cur_op = op; cur_fn = fn;
        wait_phase(1, flat, ok);
        while (!ok) wait_phase(1, 0, ok);
        o = step_out(2);
        if (!is_legal(op, fn)) begin
            o.ill = 1;
            push(o, 1'b1, 1'b0, 1'($urandom));
            return;
        end
        push(o, 1'b1, 1'b0, 1'($urandom));
        case (op)
            6'h00: begin
                o = step_out(7); o.alu = alu_of(fn);
                push(o, 1'b1, 1'b0, 1'($urandom));
                push(step_out(8), 1'b1, 1'b0, 1'($urandom));
            end
            6'h23: begin
                push(step_out(3), 1'b1, 1'b0, 1'($urandom));
                wait_phase(4, mlat, ok);
                if (ok) push(step_out(5), 1'b1, 1'b0, 1'($urandom));
            end
            6'h2B: begin
                push(step_out(3), 1'b1, 1'b0, 1'($urandom));
                wait_phase(6, mlat, ok);
            end
            6'h04, 6'h05: begin
                iz = (izmode == 2) ? 1'($urandom) : 1'(izmode);
                o = step_out(9);
                o.pc_en = (op == 6'h04) ? iz : ~iz;
                push(o, 1'b1, 1'b0, iz);
            end
            6'h08: begin
                push(step_out(10), 1'b1, 1'b0, 1'($urandom));
                push(step_out(11), 1'b1, 1'b0, 1'($urandom));
            end
            default: push(step_out(12), 1'b1, 1'b0, 1'($urandom));
        endcase
    endtask

    // add interrupted by reset during EXEC: no ALUWB may follow.
    task automatic gen_reset_mid_exec();
        bit   ok;
        out_t o;
        cur_id++;
        cur_op = 6'h00; cur_fn = 6'h20;
        wait_phase(1, 0, ok);
        push(step_out(2), 1'b1, 1'b0, 1'b0);
        o = step_out(7); o.alu = 4'd2;
        push(o, 1'b0, 1'b0, 1'b0);
        push('0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst_n = c.rst; opcode = c.op; funct = c.fn; mem_ready = c.rdy; isZero = c.iz;
            #1;
            chk("cycle", c.id, 32'(act), 32'(c.exp));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        disp_t dtab [15];
        logic [5:0] rop, rfn;
        int         flat, mlat;

        dtab[0]  = '{6'h00, 6'h20, 1'b0, 4'd7,  4'd2};
        dtab[1]  = '{6'h00, 6'h22, 1'b0, 4'd7,  4'd6};
        dtab[2]  = '{6'h00, 6'h24, 1'b0, 4'd7,  4'd0};
        dtab[3]  = '{6'h00, 6'h25, 1'b0, 4'd7,  4'd1};
        dtab[4]  = '{6'h00, 6'h27, 1'b0, 4'd7,  4'd12};
        dtab[5]  = '{6'h00, 6'h2A, 1'b0, 4'd7,  4'd7};
        dtab[6]  = '{6'h00, 6'h01, 1'b1, 4'd1,  4'd2};
        dtab[7]  = '{6'h00, 6'h21, 1'b1, 4'd1,  4'd2};
        dtab[8]  = '{6'h23, 6'h15, 1'b0, 4'd3,  4'd2};
        dtab[9]  = '{6'h2B, 6'h00, 1'b0, 4'd3,  4'd2};
        dtab[10] = '{6'h04, 6'h3F, 1'b0, 4'd9,  4'd6};
        dtab[11] = '{6'h08, 6'h20, 1'b0, 4'd10, 4'd2};
        dtab[12] = '{6'h02, 6'h00, 1'b0, 4'd12, 4'd0};
        dtab[13] = '{6'h3F, 6'h20, 1'b1, 4'd1,  4'd2};
`ifdef MIPS_CTRL_BNE_EN
        dtab[14] = '{6'h05, 6'h00, 1'b0, 4'd9,  4'd6};
`else
        dtab[14] = '{6'h05, 6'h00, 1'b1, 4'd1,  4'd2};
`endif

        rst_n = 1'b0;
        @(posedge clk);
        cur_op = 6'h00; cur_fn = 6'h00;
        push('0, 1'b0, 1'b0, 1'b0);
        push('0, 1'b0, 1'b0, 1'b0);
        push('0, 1'b1, 1'b0, 1'b0);

        gen_instr(6'h00, 6'h20, 0, 0, 2);   // add
        gen_instr(6'h23, 6'h11, 0, 3, 2);   // lw, ready after 3 idle cycles
        gen_instr(6'h2B, 6'h00, 2, 0, 2);   // sw, slow fetch
        gen_instr(6'h04, 6'h00, 0, 0, 1);   // beq taken
        gen_instr(6'h04, 6'h00, 0, 0, 0);   // beq not taken
        gen_instr(6'h05, 6'h00, 0, 0, 1);   // bne, isZero=1
        gen_instr(6'h05, 6'h00, 0, 0, 0);   // bne, isZero=0
        gen_instr(6'h08, 6'h00, 0, 0, 2);   // addi
        gen_instr(6'h02, 6'h00, 0, 0, 2);   // j
        gen_instr(6'h3F, 6'h20, 0, 0, 2);   // illegal opcode
        gen_instr(6'h00, 6'h01, 0, 0, 2);   // illegal funct
        gen_instr(6'h2B, 6'h00, 0, 15, 2);  // sw timeout
        gen_instr(6'h23, 6'h00, 0, 14, 2);  // lw, ready in the timeout cycle
        gen_instr(6'h00, 6'h2A, 15, 0, 2);  // fetch timeout then retry
        gen_reset_mid_exec();
        gen_instr(6'h00, 6'h22, 0, 0, 2);
        run_q();

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1: begin rop = 6'h00; rfn = legal_fns[$urandom_range(0, 5)]; end
                2:    begin rop = 6'h00; rfn = 6'($urandom); end
                3:    begin rop = 6'h23; rfn = 6'($urandom); end
                4:    begin rop = 6'h2B; rfn = 6'($urandom); end
                5:    begin rop = 6'h04; rfn = 6'($urandom); end
                6:    begin rop = 6'h05; rfn = 6'($urandom); end
                7:    begin rop = 6'h08; rfn = 6'($urandom); end
                8:    begin rop = 6'h02; rfn = 6'($urandom); end
                default: begin rop = 6'($urandom); rfn = 6'($urandom); end
            endcase
            flat = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       mlat = TMO;
                1:       mlat = TMO - 1;
                default: mlat = int'($urandom_range(0, 4));
            endcase
            gen_instr(rop, rfn, flat, mlat, 2);
        end
        run_q();

        // Dispatch table: each entry starts sampled in FETCH with mem_ready high.
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1; isZero = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            opcode = dtab[i].op; funct = dtab[i].fn;
            chk("disp_fetch", i, 32'(state_dbg), 32'd1);
            @(negedge clk); #1;
            chk("disp_illegal", i, 32'(illegal), 32'(dtab[i].exp_ill));
            @(negedge clk); #1;
            chk("disp_next", i, 32'(state_dbg), 32'(dtab[i].exp_next));
            chk("disp_alu", i, 32'(ALUcontrol), 32'(dtab[i].exp_alu));
            for (int k = 0; k < 20 && state_dbg != 4'd1; k++) begin
                @(negedge clk); #1;
            end
            chk("disp_drain", i, 32'(state_dbg), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
